// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared constants, conversion-state encoding and 7-segment helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam int          DP_DIGIT   = 3;
    localparam logic [26:0] T_MAX      = 27'd99999999;

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_CONV    = 2'd1;
    localparam logic [1:0]  ST_LOAD    = 2'd2;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0]  SEG_0      = 7'h40;
    localparam logic [6:0]  SEG_1      = 7'h79;
    localparam logic [6:0]  SEG_2      = 7'h24;
    localparam logic [6:0]  SEG_3      = 7'h30;
    localparam logic [6:0]  SEG_4      = 7'h19;
    localparam logic [6:0]  SEG_5      = 7'h12;
    localparam logic [6:0]  SEG_6      = 7'h02;
    localparam logic [6:0]  SEG_7      = 7'h78;
    localparam logic [6:0]  SEG_8      = 7'h00;
    localparam logic [6:0]  SEG_9      = 7'h10;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] bcd_adjust(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble, 27-bit binary to 8-digit BCD, 29 cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [26:0] bin_i,
    output logic [31:0] bcd_o,
    output logic        done_o
);

    logic [1:0]  state_q, state_d;
    logic [26:0] bin_q,   bin_d;
    logic [31:0] bcd_q,   bcd_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] adj_w;

    assign adj_w = bcd_adjust(bcd_q);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = (adj_w << 1) | {31'd0, bin_q[26]};
                bin_d = bin_q << 1;
                if (cnt_q == 5'd26) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = (state_q == ST_LOAD);

endmodule

`default_nettype wire

// File: rtl/stopwatch_display.sv
// ============================================================================
// Module   : stopwatch_display
// Brief    : 8-digit multiplexed 7-segment driver for a millisecond stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [38:0] t,
    input  logic        zero,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [26:0]           t_sat_w;
    logic [31:0]           bcd_w;
    logic                  done_w;
    logic [31:0]           digits_q;
    logic [RW-1:0]         refresh_q;
    logic [2:0]            idx_q;
    logic [BW-1:0]         blink_q;
    logic                  phase_q;
    logic [31:0]           shifted_w;
    logic                  blank_w;
    logic                  lit_w;
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q,  dp_d;

    assign t_sat_w = (t > {12'd0, T_MAX}) ? T_MAX : t[26:0];

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (1'b1),
        .bin_i   (t_sat_w),
        .bcd_o   (bcd_w),
        .done_o  (done_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
        end else if (done_w) begin
            digits_q <= bcd_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == REFRESH_LAST) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 3'd1;
        end else begin
            refresh_q <= refresh_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            phase_q <= 1'b0;
        end else if (!zero) begin
            blink_q <= '0;
            phase_q <= 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            blink_q <= blink_q + BW'(1);
        end
    end

    // Upper digits are blanked only when this digit and everything above it is zero
    assign shifted_w = digits_q >> {idx_q, 2'b00};
    assign blank_w   = idx_q[2] && (shifted_w == 32'd0);
    assign lit_w     = !blank_w && !(zero && phase_q);

    always_comb begin
        an_d  = lit_w ? ~(8'd1 << idx_q) : 8'hFF;
        seg_d = seg_decode(shifted_w[3:0]);
        dp_d  = !(lit_w && (idx_q == 3'(DP_DIGIT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_display.sv
// ============================================================================
// Module   : tb_stopwatch_display
// Brief    : Self-checking bench for stopwatch_display with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_display;

    localparam int RDIV = 4;
    localparam int BDIV = 16;
    localparam int PASS = 29;

    logic        clk = 1'b0;
    logic        rst;
    logic [38:0] t;
    logic        zero;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    always #5 clk = ~clk;

    stopwatch_display #(
        .REFRESH_DIV (RDIV),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .zero (zero),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic longint sat(input logic [38:0] v);
        return (v > 39'd99999999) ? 64'd99999999 : longint'(v);
    endfunction

    function automatic longint p10(input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // Reference model: state expressed as edges since reset, latched/displayed values
    longint m_n, m_lat, m_disp, m_b;
    bit     m_valid = 1'b0;

    always begin
        int         k;
        int         d;
        bit         blank, phase, lit, seg_ok;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        @(posedge clk);
        seg_ok  = 1'b0;
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        if (rst) begin
            m_n = 0; m_lat = 0; m_disp = 0; m_b = 0;
            m_valid = 1'b1;
            seg_ok  = 1'b1;
        end else if (m_valid) begin
            k      = int'((m_n / RDIV) % 8);
            d      = int'((m_disp / p10(k)) % 10);
            blank  = (k >= 4) && (m_disp < p10(k));
            phase  = ((m_b / BDIV) % 2) == 1;
            lit    = !blank && !(zero && phase);
            exp_an = lit ? ~(8'd1 << k) : 8'hFF;
            exp_seg = seg_tab[d];
            seg_ok = lit;
            exp_dp = !(lit && k == 3);
            if (m_n % PASS == 0)  m_lat  = sat(t);
            if (m_n % PASS == 28) m_disp = m_lat;
            m_n++;
            m_b = zero ? m_b + 1 : 0;
        end
        #1;
        if (m_valid) begin
            check("model_an", {24'd0, an}, {24'd0, exp_an});
            check("model_dp", {31'd0, dp}, {31'd0, exp_dp});
            if (seg_ok) check("model_seg", {25'd0, seg}, {25'd0, exp_seg});
        end
    end

    typedef struct {
        logic [38:0]      tv;
        logic [7:0][6:0]  segs;
        logic [7:0]       blank;
    } vec_t;

    vec_t vecs [7];

    task automatic pulse_reset(input logic [38:0] tv);
        @(negedge clk);
        rst  = 1'b1;
        t    = tv;
        zero = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        logic [7:0]  exp_an;
        int          slot;
        int          cnt_blank, cnt_norm;

        vecs[0] = '{39'd1234567,   {7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 8'h80};
        vecs[1] = '{39'd0,         {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hF0};
        vecs[2] = '{39'd100000000, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}, 8'h00};
        vecs[3] = '{39'd5000,      {7'h40,7'h40,7'h40,7'h40,7'h12,7'h40,7'h40,7'h40}, 8'hF0};
        vecs[4] = '{39'd10000,     {7'h40,7'h40,7'h40,7'h79,7'h40,7'h40,7'h40,7'h40}, 8'hE0};
        vecs[5] = '{39'd87654321,  {7'h00,7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79}, 8'h00};
        vecs[6] = '{39'h7F_FFFF_FFFF, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}, 8'h00};

        rst = 1'b1; t = '0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_an",  {24'd0, an},  32'hFF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp",  {31'd0, dp},  32'h1);
        @(negedge clk);
        rst = 1'b0;
        t   = 39'd87654321;

        // Asynchronous reset mid-run, then first load timing
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an",  {24'd0, an},  32'hFF);
        check("async_rst_seg", {25'd0, seg}, 32'h7F);
        check("async_rst_dp",  {31'd0, dp},  32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 29) check("pre_load_an", {24'd0, an}, 32'hFF);
            if (e == 30) begin
                check("first_load_an",  {24'd0, an},  32'h7F);
                check("first_load_seg", {25'd0, seg}, 32'h00);
            end
        end

        // Table-driven display vectors
        for (int i = 0; i < 7; i++) begin
            pulse_reset(vecs[i].tv);
            for (int e = 1; e <= 62; e++) begin
                @(posedge clk); #1;
                if (e >= 31) begin
                    slot   = ((e - 1) / RDIV) % 8;
                    exp_an = vecs[i].blank[slot] ? 8'hFF : ~(8'd1 << slot);
                    check("vec_an", {24'd0, an}, {24'd0, exp_an});
                    check("vec_dp", {31'd0, dp},
                          {31'd0, !(slot == 3 && !vecs[i].blank[slot])});
                    if (!vecs[i].blank[slot])
                        check("vec_seg", {25'd0, seg}, {25'd0, vecs[i].segs[slot]});
                end
            end
        end

        // Input change during conversion does not disturb the pass in progress
        pulse_reset(39'd1234567);
        for (int e = 1; e <= 65; e++) begin
            @(posedge clk); #1;
            if (e == 5)  t = 39'd7654321;
            if (e == 33) check("midconv_old_seg", {25'd0, seg}, 32'h78);
            if (e == 65) check("midconv_new_seg", {25'd0, seg}, 32'h79);
        end

        // Blink while zero is high, immediate recovery when it drops
        pulse_reset(39'd87654321);
        repeat (40) @(negedge clk);
        zero = 1'b1;
        cnt_blank = 0;
        cnt_norm  = 0;
        for (int e = 1; e <= 53; e++) begin
            @(posedge clk); #1;
            if (e >= 17 && e <= 32 && an == 8'hFF) cnt_blank++;
            if (e >= 33 && e <= 48 && an != 8'hFF) cnt_norm++;
            if (e == 52) begin
                check("blink_on_an", {24'd0, an}, 32'hFF);
                zero = 1'b0;
            end
            if (e == 53) check("blink_release", {31'd0, an != 8'hFF}, 32'h1);
        end
        check("blink_dark_cycles", cnt_blank, 16);
        check("blink_lit_cycles",  cnt_norm,  16);

        // Randomized run checked by the model
        pulse_reset(39'd0);
        for (int it = 0; it < 70; it++) begin
            case ($urandom_range(0, 3))
                0: t = 39'($urandom_range(0, 9999));
                1: t = 39'($urandom % 100000000);
                2: begin r64 = {$urandom, $urandom}; t = r64[38:0]; end
                default: t = 39'(99999999 + $urandom_range(0, 2));
            endcase
            zero = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 90)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (1 kHz per digit at 100 MHz).
REQ-002 Parameter BLINK_DIV, default 50000000, clk cycles per half-period of the zero-blink.
REQ-003 clk  input  1  system clock, 100 MHz; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 t  input  39  elapsed/remaining time in milliseconds from stopwatch, unsigned binary.
REQ-006 zero  input  1  countdown expired; display blinks while high.
REQ-007 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  output  1  decimal point cathode, active-low.
REQ-009 an  output  8  digit anodes, active-low, an[0] = rightmost digit.

Function
REQ-010 Display shows t as 8 decimal digits, digit 0 = ms units; t > 99999999 SHALL saturate to 99999999.
REQ-011 Conversion FSM states IDLE -> CONV -> LOAD -> IDLE, free-running, no external handshake.
REQ-012 IDLE (1 cycle): latch saturated t into 27-bit shift register, clear BCD accumulator.
REQ-013 CONV (exactly 27 cycles): per cycle, add 3 to every BCD nibble >= 5, then shift left one bit (double-dabble).
REQ-014 LOAD (1 cycle): copy 32-bit BCD result into display digit register; one pass = 29 cycles.
REQ-015 Change of t during CONV/LOAD SHALL NOT disturb the pass in progress; new value displayed within 58 cycles of change.
REQ-016 Refresh counter counts 0..REFRESH_DIV-1, wraps; on wrap, 3-bit digit index increments, 7 wraps to 0.
REQ-017 Exactly one an bit low at a time (index position), others high, except when blanked (REQ-018, REQ-019).
REQ-018 Leading-zero blanking: digit k (k >= 4) blanked (an all high) when it and all digits above are 0; digits 0..3 always lit ("0.000").
REQ-019 Blink counter counts 0..BLINK_DIV-1, phase bit toggles on wrap; while zero=1 and phase=1, an = 8'hFF; zero=0 SHALL clear phase and counter.
REQ-020 dp = 0 only while digit 3 is selected and lit; otherwise 1.
REQ-021 seg = standard 0-9 pattern of selected digit (0=7'h40, 4=7'h19, 7=7'h78, 9=7'h10); codes 10-15 SHALL give 7'h7F.
REQ-022 seg, dp, an SHALL be registered outputs (one cycle after index change).

Reset
REQ-023 rst=1 SHALL immediately force an=8'hFF, seg=7'h7F, dp=1.
REQ-024 rst SHALL clear FSM to IDLE, digit register to 0, refresh/blink counters, digit index and phase to 0.
REQ-025 Reset mid-conversion SHALL abort the pass; first pass after release starts in IDLE.

Structure
REQ-026 Shared package stopwatch_pkg SHALL hold NUM_DIGITS=8, DP_DIGIT=3, T_MAX=99999999, conversion-state encoding, 7-seg code constants.
REQ-027 Double-dabble datapath SHALL be a sub-module bin2bcd_seq (start, 27-bit in, 32-bit BCD out, done pulse); decode and scan stay in stopwatch_display.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-028 Assert rst mid-run -> same cycle an=8'hFF, seg=7'h7F, dp=1; after release first LOAD at cycle 29.
REQ-029 t=1234567 -> after 29 cycles digits 01234567; slot 0 seg=7'h78; slot 3 seg=7'h19, dp=0; slot 7 an=8'hFF (leading zero).
REQ-030 t=0 -> slots 0..3 seg=7'h40, dp=0 on slot 3 only; slots 4..7 an=8'hFF.
REQ-031 t=100000000 -> all 8 slots seg=7'h10, no blanking.
REQ-032 zero=1 with t=5000 -> an=8'hFF for 16 cycles, normal scan 16 cycles, repeating; zero=0 -> normal scan next cycle.
REQ-033 t 1234567 -> 7654321 at cycle 5 of CONV -> next LOAD shows 01234567, following LOAD shows 07654321.
